// File: rtl/led_bank_ctrl.sv
// -----------------------------------------------------------------------------
// led_bank_ctrl
//
// Overlays a horizontal row of N_LEDS sprite LEDs onto a VGA raster. Each LED
// is a 32x32 sprite taken from one of two external ROMs (lit / unlit). The
// sprite address is shared by both ROMs, and the LED state selects which ROM
// word is shown.
//
// Pipeline (fixed 3-clock latency, 1 pixel per clock):
//   stage 1 : box decode -> hit, LED state, ROM address
//   stage 2 : ROM read cycle; hit/state/syncs delayed to stay aligned
//   stage 3 : output mux (lit / unlit / background / blank)
//
// The LED states come from a shadow register that is loaded only on
// frame_start, so the bank never tears mid-frame.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   x, y                       current pixel coordinate (10-bit)
//   de_in, hsync_in, vsync_in  raster timing for (x,y)
//   frame_start                one-cycle pulse, loads the shadow register
//   value                      requested LED states, MSB = leftmost LED
//   lamp_test                  forces every LED lit
//   bg                         RGB565 background colour
//   rom_ad, rom_ce, rom_oce    shared sprite ROM address / enables
//   rom_on_dout, rom_off_dout  lit / unlit ROM read data
//   rgb                        RGB565 output pixel
//   de_out, hsync_out, vsync_out  timing aligned with rgb
// -----------------------------------------------------------------------------
module led_bank_ctrl #(
    parameter int N_LEDS = 8,
    parameter int X0     = 64,
    parameter int Y0     = 224,
    parameter int PITCH  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              frame_start,
    input  logic [N_LEDS-1:0] value,
    input  logic              lamp_test,
    input  logic [15:0]       bg,
    output logic [9:0]        rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    input  logic [15:0]       rom_on_dout,
    input  logic [15:0]       rom_off_dout,
    output logic [15:0]       rgb,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam logic [31:0] Y_LO = 32'(Y0);
    localparam logic [31:0] Y_HI = 32'(Y0 + 31);

    logic [N_LEDS-1:0] shadow_q;

    // stage 1
    logic        hit_s1_q,   hit_d;
    logic        state_s1_q, state_d;
    logic [9:0]  rom_ad_q,   rom_ad_d;

    // stage 2
    logic        hit_s2_q;
    logic        state_s2_q;

    // sync delay lines (3 taps)
    logic [2:0]  de_q;
    logic [2:0]  hs_q;
    logic [2:0]  vs_q;

    // stage 3
    logic [15:0] rgb_q, rgb_d;

    // decode helpers
    logic [31:0] x_w, y_w, led_lo;
    logic        in_y, led_hit, led_state;
    logic [4:0]  row_off, col_off;
    logic [15:0] rom_sel;

    // Coordinates are widened before comparing so that an LED box that would
    // run past x=1023 simply never matches instead of wrapping round to x=0.
    always_comb begin
        x_w       = {22'd0, x};
        y_w       = {22'd0, y};
        in_y      = (y_w >= Y_LO) && (y_w <= Y_HI);
        row_off   = 5'(y_w - Y_LO);
        led_hit   = 1'b0;
        led_state = 1'b0;
        col_off   = 5'd0;
        led_lo    = 32'd0;
        for (int i = 0; i < N_LEDS; i++) begin
            led_lo = 32'(X0 + i * PITCH);
            if ((x_w >= led_lo) && (x_w <= led_lo + 32'd31)) begin
                led_hit   = 1'b1;
                // LED 0 is leftmost and maps to the MSB of the shadow
                led_state = shadow_q[N_LEDS-1-i];
                col_off   = 5'(x_w - led_lo);
            end
        end
    end

    always_comb begin
        hit_d    = de_in & in_y & led_hit;
        state_d  = led_state | lamp_test;
        // address is held outside the boxes to avoid needless ROM toggling
        rom_ad_d = hit_d ? {row_off, col_off} : rom_ad_q;
    end

    // A zero ROM word is the sprite's transparent colour.
    always_comb begin
        rom_sel = state_s2_q ? rom_on_dout : rom_off_dout;
        rgb_d   = 16'h0000;
        if (de_q[1]) begin
            if (hit_s2_q && (rom_sel != 16'h0000)) begin
                rgb_d = rom_sel;
            end else begin
                rgb_d = bg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q   <= '0;
            hit_s1_q   <= 1'b0;
            state_s1_q <= 1'b0;
            rom_ad_q   <= 10'd0;
            hit_s2_q   <= 1'b0;
            state_s2_q <= 1'b0;
            de_q       <= 3'b000;
            hs_q       <= 3'b000;
            vs_q       <= 3'b000;
            rgb_q      <= 16'h0000;
        end else begin
            if (frame_start) begin
                shadow_q <= value;
            end
            hit_s1_q   <= hit_d;
            state_s1_q <= state_d;
            rom_ad_q   <= rom_ad_d;
            hit_s2_q   <= hit_s1_q;
            state_s2_q <= state_s1_q;
            de_q       <= {de_q[1:0], de_in};
            hs_q       <= {hs_q[1:0], hsync_in};
            vs_q       <= {vs_q[1:0], vsync_in};
            rgb_q      <= rgb_d;
        end
    end

    assign rom_ad    = rom_ad_q;
    assign rom_ce    = hit_s1_q;
    assign rom_oce   = 1'b1;
    assign rgb       = rgb_q;
    assign de_out    = de_q[2];
    assign hsync_out = hs_q[2];
    assign vsync_out = vs_q[2];

endmodule

// File: tb/tb_led_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_bank_ctrl
//
// Self-checking bench for led_bank_ctrl with default parameters. Two behavioural
// sprite ROMs (one-cycle read latency) feed the DUT. Every driven pixel pushes
// its expected rgb/syncs onto a scoreboard queue that is popped three clocks
// later; rom_ce/rom_ad are checked one clock after each pixel.
// -----------------------------------------------------------------------------
module tb_led_bank_ctrl;

    localparam logic [15:0] BG = 16'hBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        de_in, hsync_in, vsync_in, frame_start;
    logic [7:0]  value;
    logic        lamp_test;
    logic [15:0] bg;
    logic [9:0]  rom_ad;
    logic        rom_ce, rom_oce;
    logic [15:0] rom_on_dout, rom_off_dout;
    logic [15:0] rgb;
    logic        de_out, hsync_out, vsync_out;

    led_bank_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .frame_start (frame_start),
        .value       (value),
        .lamp_test   (lamp_test),
        .bg          (bg),
        .rom_ad      (rom_ad),
        .rom_ce      (rom_ce),
        .rom_oce     (rom_oce),
        .rom_on_dout (rom_on_dout),
        .rom_off_dout(rom_off_dout),
        .rgb         (rgb),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    always #5 clk = ~clk;

    // Sprite contents: one transparent word in each ROM.
    function automatic logic [15:0] rom_on_f(input logic [9:0] a);
        return (a == 10'h021) ? 16'h0000 : {6'h3C, a};
    endfunction

    function automatic logic [15:0] rom_off_f(input logic [9:0] a);
        return (a == 10'h042) ? 16'h0000 : {6'h15, a};
    endfunction

    initial begin
        rom_on_dout  = 16'h0000;
        rom_off_dout = 16'h0000;
    end

    always @(posedge clk) begin
        if (rom_ce) begin
            rom_on_dout  <= rom_on_f(rom_ad);
            rom_off_dout <= rom_off_f(rom_ad);
        end
    end

    typedef struct packed {
        logic [15:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct packed {
        logic [15:0] rgb;
        logic        ce;
        logic [9:0]  ad;
    } mres_t;

    typedef struct {
        int          px;
        int          py;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ce;
        logic [9:0]  ad;
        logic [15:0] rgb;
    } vec_t;

    exp_t        sbq[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic        pend_valid;
    logic        pend_ce;
    logic [9:0]  pend_ad;
    logic [9:0]  last_ad;
    logic [7:0]  m_shadow;
    vec_t        tbl[14];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: geometry of the default bank, computed arithmetically.
    function automatic mres_t model(input int px, input int py, input logic de,
                                    input logic [7:0] sh, input logic lp);
        mres_t       r;
        logic [15:0] w;
        int          lo;
        r.ce  = 1'b0;
        r.ad  = 10'd0;
        r.rgb = de ? BG : 16'h0000;
        if (de && py >= 224 && py <= 255) begin
            for (int i = 0; i < 8; i++) begin
                lo = 64 + 40 * i;
                if (px >= lo && px <= lo + 31) begin
                    r.ce  = 1'b1;
                    r.ad  = 10'((py - 224) * 32 + (px - lo));
                    w     = (sh[7-i] | lp) ? rom_on_f(r.ad) : rom_off_f(r.ad);
                    r.rgb = (w == 16'h0000) ? BG : w;
                end
            end
        end
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (pend_valid) begin
            chk1("rom_ce", rom_ce, pend_ce);
            if (pend_ce) begin
                chk16("rom_ad", {6'd0, rom_ad}, {6'd0, pend_ad});
                last_ad = pend_ad;
            end else begin
                chk16("rom_ad_hold", {6'd0, rom_ad}, {6'd0, last_ad});
            end
        end
        if (sbq.size() >= 3) begin
            e = sbq.pop_front();
            chk16("rgb", rgb, e.rgb);
            chk1("de_out", de_out, e.de);
            chk1("hsync_out", hsync_out, e.hs);
            chk1("vsync_out", vsync_out, e.vs);
        end else begin
            // pipeline still holding its reset contents
            chk16("flush_rgb", rgb, 16'h0000);
            chk1("flush_de", de_out, 1'b0);
        end
    endtask

    task automatic drive(input int px, input int py, input logic de, input logic hs,
                         input logic vs, input logic fs, input logic [15:0] e_rgb,
                         input logic e_ce, input logic [9:0] e_ad);
        exp_t e;
        x           = 10'(px);
        y           = 10'(py);
        de_in       = de;
        hsync_in    = hs;
        vsync_in    = vs;
        frame_start = fs;
        e.rgb = e_rgb;
        e.de  = de;
        e.hs  = hs;
        e.vs  = vs;
        sbq.push_back(e);
        pend_valid = 1'b1;
        pend_ce    = e_ce;
        pend_ad    = e_ad;
        if (fs) m_shadow = value;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drive_m(input int px, input int py, input logic de, input logic hs,
                           input logic vs, input logic fs);
        mres_t r;
        r = model(px, py, de, m_shadow, lamp_test);
        drive(px, py, de, hs, vs, fs, r.rgb, r.ce, r.ad);
    endtask

    task automatic reset_checks(input string tag);
        chk16({tag, "_rgb"}, rgb, 16'h0000);
        chk1({tag, "_de"}, de_out, 1'b0);
        chk1({tag, "_hs"}, hsync_out, 1'b0);
        chk1({tag, "_vs"}, vsync_out, 1'b0);
        chk1({tag, "_ce"}, rom_ce, 1'b0);
        chk16({tag, "_ad"}, {6'd0, rom_ad}, 16'h0000);
    endtask

    initial begin
        // px, py, de, hs, vs, ce, ad, rgb   (shadow = 8'b1000_0000, lamp off)
        tbl[0]  = '{64,   224,  1'b1, 1'b1, 1'b0, 1'b1, 10'h000, 16'hF000};
        tbl[1]  = '{104,  224,  1'b1, 1'b0, 1'b1, 1'b1, 10'h000, 16'h5400};
        tbl[2]  = '{95,   255,  1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF, 16'hF3FF};
        tbl[3]  = '{96,   255,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000, BG};
        tbl[4]  = '{95,   256,  1'b1, 1'b1, 1'b0, 1'b0, 10'h000, BG};
        tbl[5]  = '{65,   225,  1'b1, 1'b0, 1'b1, 1'b1, 10'h021, BG};
        tbl[6]  = '{106,  226,  1'b1, 1'b1, 1'b1, 1'b1, 10'h042, BG};
        tbl[7]  = '{70,   230,  1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 16'h0000};
        tbl[8]  = '{63,   224,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000, BG};
        tbl[9]  = '{64,   223,  1'b1, 1'b0, 1'b1, 1'b0, 10'h000, BG};
        tbl[10] = '{375,  255,  1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF, 16'h57FF};
        tbl[11] = '{376,  240,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000, BG};
        tbl[12] = '{1023, 1023, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, BG};
        tbl[13] = '{150,  240,  1'b1, 1'b0, 1'b1, 1'b1, 10'h206, 16'h5606};

        reset       = 1'b1;
        x           = 10'd0;
        y           = 10'd0;
        de_in       = 1'b0;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        frame_start = 1'b0;
        value       = 8'h00;
        lamp_test   = 1'b0;
        bg          = BG;
        pend_valid  = 1'b0;
        pend_ce     = 1'b0;
        pend_ad     = 10'd0;
        last_ad     = 10'd0;
        m_shadow    = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        reset_checks("init");
        chk1("rom_oce", rom_oce, 1'b1);
        reset = 1'b0;

        // latch 1000_0000 on an idle pixel
        value = 8'b1000_0000;
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 10'd0);
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].px, tbl[i].py, tbl[i].de, tbl[i].hs, tbl[i].vs, 1'b0,
                  tbl[i].rgb, tbl[i].ce, tbl[i].ad);
        end

        // value change without frame_start must not show
        value = 8'b0100_0000;
        drive(64,  224, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF000, 1'b1, 10'd0);
        drive(104, 224, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5400, 1'b1, 10'd0);
        // frame_start pixel still uses the old shadow, next pixel the new one
        drive(64,  224, 1'b1, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b1, 10'd0);
        drive(64,  224, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5400, 1'b1, 10'd0);
        drive(104, 224, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF000, 1'b1, 10'd0);

        // lamp test lights every LED
        lamp_test = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(64 + 40 * i, 224, 1'b1, 1'b1, 1'b0, 1'b0, 16'hF000, 1'b1, 10'd0);
        end
        lamp_test = 1'b0;

        // reset for two cycles in the middle of active video
        x        = 10'd70;
        y        = 10'd230;
        de_in    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset_checks("rst1");
        value       = 8'hFF;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        reset_checks("rst2");
        reset       = 1'b0;
        frame_start = 1'b0;
        sbq.delete();
        pend_valid = 1'b0;
        last_ad    = 10'd0;
        m_shadow   = 8'h00;
        // shadow must be 0 even though value=FF was presented during reset
        drive(64,  224, 1'b1, 1'b1, 1'b1, 1'b0, 16'h5400, 1'b1, 10'd0);
        drive(104, 224, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd0);
        drive(0,   0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd0);
        drive(104, 224, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5400, 1'b1, 10'd0);

        // random raster sweep against the model
        for (int n = 0; n < 1500; n++) begin
            logic fs;
            fs = ($urandom_range(0, 99) == 0);
            if (fs) value = 8'($urandom);
            lamp_test = ($urandom_range(0, 49) == 0);
            drive_m(int'($urandom_range(420, 40)), int'($urandom_range(280, 200)),
                    ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), fs);
        end
        lamp_test = 1'b0;

        repeat (3) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd0);
        chk1("rom_oce_end", rom_oce, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
